rc4_phase_sequencer: RTL and testbench
======================================

# rc4_phase_sequencer

Top-level sequencer for the RC4 decryption datapath. It runs the three S-RAM engines in a fixed order: init (s[i]=i), key-schedule shuffle, then keystream/decrypt. It owns the single-port S-RAM and multiplexes it to whichever engine is active. It generates one-cycle start pulses, collects each engine's finished, and applies a per-phase watchdog. It sits between the top-level controller (start/done) and the engines plus the S-RAM.

## Interface
- RAM_WIDTH, 8: S-RAM data width in bits.
- RAM_LENGTH, 8: S-RAM address width in bits.
- TIMEOUT_CYCLES, 4096: maximum cycles allowed per phase, counted from that phase's start pulse. Legal range is ≥ 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin a full init→shuffle→decrypt run. Sampled as a level; acted on only in IDLE, DONE or ERROR.
- busy  out  1  high from the cycle after start is accepted until DONE or ERROR is entered.
- done  out  1  high in DONE; held until the next accepted start or reset.
- error  out  1  high in ERROR; held until the next accepted start or reset.
- phase  out  2  active phase: 0 = none, 1 = init, 2 = shuffle, 3 = decrypt.
- init_start, shuf_start, dec_start  out  1 each  one-cycle start pulses to the engines.
- init_finished, shuf_finished, dec_finished  in  1 each  engine completion flags.
- init_addr, shuf_addr, dec_addr  in  RAM_LENGTH each  engine address requests.
- init_data, shuf_data, dec_data  in  RAM_WIDTH each  engine write data.
- init_we, shuf_we, dec_we  in  1 each  engine write enables.
- ram_address  out  RAM_LENGTH  to S-RAM.
- ram_in  out  RAM_WIDTH  to S-RAM.
- ram_wren  out  1  to S-RAM.
- No ram_out port: S-RAM read data goes directly to all engines. Inactive engines ignore it.

## Operation
States: IDLE, INIT_GO, INIT_RUN, SHUF_GO, SHUF_RUN, DEC_GO, DEC_RUN, DONE, ERROR.

Transitions:
- IDLE/DONE/ERROR, start=1 → INIT_GO. Clears done, error and the watchdog.
- INIT_GO → INIT_RUN unconditionally. init_start is registered high for exactly this state.
- INIT_RUN, init_finished=1 → SHUF_GO.
- SHUF_GO → SHUF_RUN; shuf_start is high for this state only.
- SHUF_RUN, shuf_finished=1 → DEC_GO.
- DEC_GO → DEC_RUN; dec_start is high for this state only.
- DEC_RUN, dec_finished=1 → DONE.
- Any *_RUN state with the watchdog reaching TIMEOUT_CYCLES-1 and finished still low → ERROR. If finished and timeout occur in the same cycle, finished wins.
- start while busy is ignored. It is not queued.

Engine and RAM multiplexing:
- finished inputs from inactive engines are ignored. A stale shuf_finished during INIT_RUN must not advance the state.
- phase=1 covers INIT_GO/INIT_RUN, phase=2 covers SHUF_*, phase=3 covers DEC_*, and phase=0 covers IDLE, DONE and ERROR.
- The RAM mux is combinational, selected by the registered phase, so engine address/data/we pass through with zero added latency. This preserves each engine's read timing.
- With phase=0, ram_address=0, ram_in=0 and ram_wren=0. No engine can write outside its phase.

Watchdog:
- Width is $clog2(TIMEOUT_CYCLES).
- Cleared in every *_GO state; increments by 1 each *_RUN cycle; saturates and never wraps.

## Timing
- Reset (sync): state=IDLE. busy, done, error, all *_start and ram_wren are 0; phase=0; ram_address=0; ram_in=0; watchdog=0.
- Reset mid-run aborts at the next edge with the same values. Engines are reset separately by the same reset.
- start sampled high in IDLE at edge N:
  - Edge N → INIT_GO: init_start=1 and busy=1 during cycle N+1.
  - Edge N+1 → INIT_RUN: init_start=0.
- finished=1 sampled at edge M in *_RUN: the next *_GO state is entered at edge M, and its start pulse is high during cycle M+1.
- Phase hand-off costs exactly 1 GO cycle. Total overhead beyond the engines' own cycles is 3 GO cycles plus 1 cycle into DONE.
- *_start pulses are exactly one cycle and are low between runs, so the engines' edge detectors re-trigger.
- done/error rise the cycle after the terminating edge; busy falls on the same edge.

## Test plan
- Nominal run: pulse start; engine models assert finished after 256, 1536 and 768 cycles. Required: phase sequence 1→2→3→0; each *_start is a single-cycle pulse; done=1 and busy=0 exactly 3+256+1536+768+1 cycles after start, within ±1 for the model's finished latency.
- Mux isolation: in phase 2, drive init_we=1 with init_addr=0x55 and shuf_we=0. Required: ram_wren=0 and ram_address equals shuf_addr. In DONE, all engines drive we=1; required: ram_wren=0.
- Stale finished: hold shuf_finished=1 throughout INIT_RUN. Required: no SHUF_GO until init_finished. Then shuf_finished high on entry to SHUF_RUN advances to DEC_GO one cycle after SHUF_GO.
- Timeout: TIMEOUT_CYCLES=16; the shuffle model never finishes. Required: ERROR entered 16 cycles after the shuf_start pulse; error=1, busy=0, ram_wren=0. Then start → INIT_GO with error cleared.
- Tie: TIMEOUT_CYCLES=16; dec_finished asserts on the terminal watchdog cycle. Required: DONE, not ERROR.
- Reset mid-shuffle with start held high: assert reset during SHUF_RUN. Required: all outputs at reset values on the next cycle. After reset deasserts, start (still high) is accepted in IDLE.

Source files
------------

// File: rtl/rc4_phase_sequencer.sv
// Runs the RC4 init, key-schedule shuffle and decrypt engines in order, owns the
// single-port S-RAM mux, and aborts any phase whose engine overruns the watchdog.
module rc4_phase_sequencer #(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_LENGTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            phase,
  output logic                  init_start,
  output logic                  shuf_start,
  output logic                  dec_start,
  input  logic                  init_finished,
  input  logic                  shuf_finished,
  input  logic                  dec_finished,
  input  logic [RAM_LENGTH-1:0] init_addr,
  input  logic [RAM_LENGTH-1:0] shuf_addr,
  input  logic [RAM_LENGTH-1:0] dec_addr,
  input  logic [RAM_WIDTH-1:0]  init_data,
  input  logic [RAM_WIDTH-1:0]  shuf_data,
  input  logic [RAM_WIDTH-1:0]  dec_data,
  input  logic                  init_we,
  input  logic                  shuf_we,
  input  logic                  dec_we,
  output logic [RAM_LENGTH-1:0] ram_address,
  output logic [RAM_WIDTH-1:0]  ram_in,
  output logic                  ram_wren
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT_GO,
    INIT_RUN,
    SHUF_GO,
    SHUF_RUN,
    DEC_GO,
    DEC_RUN,
    DONE,
    ERROR
  } state_t;

  state_t          state;
  state_t          next_state;
  logic [WD_W-1:0] watchdog;
  logic            wd_expired;

  logic            next_busy;
  logic            next_done;
  logic            next_error;
  logic [1:0]      next_phase;
  logic            next_init_start;
  logic            next_shuf_start;
  logic            next_dec_start;

  assign wd_expired = (watchdog == WD_LAST);

  // Finished outranks the watchdog, so an engine completing on the last allowed cycle still passes.
  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE, ERROR: if (start) next_state = INIT_GO;
      INIT_GO:  next_state = INIT_RUN;
      INIT_RUN: begin
        if (init_finished)   next_state = SHUF_GO;
        else if (wd_expired) next_state = ERROR;
      end
      SHUF_GO:  next_state = SHUF_RUN;
      SHUF_RUN: begin
        if (shuf_finished)   next_state = DEC_GO;
        else if (wd_expired) next_state = ERROR;
      end
      DEC_GO:   next_state = DEC_RUN;
      DEC_RUN: begin
        if (dec_finished)    next_state = DONE;
        else if (wd_expired) next_state = ERROR;
      end
      default:  next_state = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so they are glitch-free flops.
  always_comb begin
    next_busy       = 1'b0;
    next_done       = 1'b0;
    next_error      = 1'b0;
    next_phase      = 2'd0;
    next_init_start = 1'b0;
    next_shuf_start = 1'b0;
    next_dec_start  = 1'b0;
    case (next_state)
      INIT_GO: begin
        next_busy       = 1'b1;
        next_phase      = 2'd1;
        next_init_start = 1'b1;
      end
      INIT_RUN: begin
        next_busy  = 1'b1;
        next_phase = 2'd1;
      end
      SHUF_GO: begin
        next_busy       = 1'b1;
        next_phase      = 2'd2;
        next_shuf_start = 1'b1;
      end
      SHUF_RUN: begin
        next_busy  = 1'b1;
        next_phase = 2'd2;
      end
      DEC_GO: begin
        next_busy      = 1'b1;
        next_phase     = 2'd3;
        next_dec_start = 1'b1;
      end
      DEC_RUN: begin
        next_busy  = 1'b1;
        next_phase = 2'd3;
      end
      DONE:    next_done  = 1'b1;
      ERROR:   next_error = 1'b1;
      default: next_busy  = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      phase      <= 2'd0;
      init_start <= 1'b0;
      shuf_start <= 1'b0;
      dec_start  <= 1'b0;
    end else begin
      state      <= next_state;
      busy       <= next_busy;
      done       <= next_done;
      error      <= next_error;
      phase      <= next_phase;
      init_start <= next_init_start;
      shuf_start <= next_shuf_start;
      dec_start  <= next_dec_start;
    end
  end

  // Watchdog restarts at every hand-off and saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      watchdog <= '0;
    end else begin
      case (state)
        INIT_GO, SHUF_GO, DEC_GO: watchdog <= '0;
        INIT_RUN, SHUF_RUN, DEC_RUN: begin
          if (watchdog != {WD_W{1'b1}}) watchdog <= watchdog + 1'b1;
        end
        default: begin
          if (start) watchdog <= '0;
        end
      endcase
    end
  end

  // Purely combinational pass-through keeps each engine's read latency unchanged.
  always_comb begin
    ram_address = '0;
    ram_in      = '0;
    ram_wren    = 1'b0;
    case (phase)
      2'd1: begin
        ram_address = init_addr;
        ram_in      = init_data;
        ram_wren    = init_we;
      end
      2'd2: begin
        ram_address = shuf_addr;
        ram_in      = shuf_data;
        ram_wren    = shuf_we;
      end
      2'd3: begin
        ram_address = dec_addr;
        ram_in      = dec_data;
        ram_wren    = dec_we;
      end
      default: ram_wren = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Scoreboard bench for rc4_phase_sequencer: one instance at the default watchdog
// for the nominal run, one at TIMEOUT_CYCLES=16 for timeout, tie and reset cases.
module tb_rc4_phase_sequencer;

  localparam int K_PHASE  = 0;
  localparam int K_ISTART = 1;
  localparam int K_SSTART = 2;
  localparam int K_DSTART = 3;
  localparam int K_DONE   = 4;
  localparam int K_ERR    = 5;

  typedef struct {
    int kind;
    int val;
    int cyc;
  } ev_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  logic [7:0] init_addr, shuf_addr, dec_addr;
  logic [7:0] init_data, shuf_data, dec_data;
  logic       init_we, shuf_we, dec_we;

  logic       reset_a, start_a, ifin_a, sfin_a, dfin_a;
  logic       busy_a, done_a, error_a, istart_a, sstart_a, dstart_a, wren_a;
  logic [1:0] phase_a;
  logic [7:0] addr_a, din_a;

  logic       reset_b, start_b, ifin_b, sfin_b, dfin_b;
  logic       busy_b, done_b, error_b, istart_b, sstart_b, dstart_b, wren_b;
  logic [1:0] phase_b;
  logic [7:0] addr_b, din_b;

  rc4_phase_sequencer dut_a (
    .clk(clk), .reset(reset_a), .start(start_a),
    .busy(busy_a), .done(done_a), .error(error_a), .phase(phase_a),
    .init_start(istart_a), .shuf_start(sstart_a), .dec_start(dstart_a),
    .init_finished(ifin_a), .shuf_finished(sfin_a), .dec_finished(dfin_a),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_we(init_we), .shuf_we(shuf_we), .dec_we(dec_we),
    .ram_address(addr_a), .ram_in(din_a), .ram_wren(wren_a)
  );

  rc4_phase_sequencer #(.TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b),
    .busy(busy_b), .done(done_b), .error(error_b), .phase(phase_b),
    .init_start(istart_b), .shuf_start(sstart_b), .dec_start(dstart_b),
    .init_finished(ifin_b), .shuf_finished(sfin_b), .dec_finished(dfin_b),
    .init_addr(init_addr), .shuf_addr(shuf_addr), .dec_addr(dec_addr),
    .init_data(init_data), .shuf_data(shuf_data), .dec_data(dec_data),
    .init_we(init_we), .shuf_we(shuf_we), .dec_we(dec_we),
    .ram_address(addr_b), .ram_in(din_b), .ram_wren(wren_b)
  );

  ev_t q_a[$];
  ev_t q_b[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic pushExp(input int d, input int kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    if (d == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic popCompare(input int d, input int kind, input int val);
    ev_t e;
    int  empty;
    empty = (d == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    if (empty != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL dut%0d_unexpected_event actual kind=%0d val=%0d required none (cycle %0d)",
               d, kind, val, cyc);
    end else begin
      if (d == 0) e = q_a.pop_front();
      else        e = q_b.pop_front();
      checkOutput($sformatf("dut%0d_ev_kind", d), kind, e.kind);
      checkOutput($sformatf("dut%0d_ev%0d_val", d, e.kind), val, e.val);
      checkOutput($sformatf("dut%0d_ev%0d_cycle", d, e.kind), cyc, e.cyc);
    end
  endtask

  // obs bits: [6:5] phase, [4] init_start, [3] shuf_start, [2] dec_start, [1] done, [0] error
  task automatic scanEvents(input int d, input logic [6:0] cur, input logic [6:0] prev);
    if (cur[6:5] != prev[6:5]) popCompare(d, K_PHASE, int'(cur[6:5]));
    for (int b = 4; b >= 0; b--) begin
      if (b >= 2 && prev[b]) checkOutput($sformatf("dut%0d_pulse_width_k%0d", d, 5 - b), int'(cur[b]), 0);
      if (cur[b] && !prev[b]) popCompare(d, 5 - b, 1);
    end
  endtask

  logic [6:0] obs_a, obs_b;
  logic [6:0] prev_a = '0;
  logic [6:0] prev_b = '0;
  assign obs_a = {phase_a, istart_a, sstart_a, dstart_a, done_a, error_a};
  assign obs_b = {phase_b, istart_b, sstart_b, dstart_b, done_b, error_b};

  // Monitor: every observed output event is popped from that instance's queue and compared.
  always @(negedge clk) begin
    if (mon_en) begin
      scanEvents(0, obs_a, prev_a);
      scanEvents(1, obs_b, prev_b);
    end
    prev_a <= obs_a;
    prev_b <= obs_b;
  end

  task automatic applyStimulus(input logic [7:0] ia, input logic [7:0] id, input logic iw,
                               input logic [7:0] sa, input logic [7:0] sd, input logic sw,
                               input logic [7:0] da, input logic [7:0] dd, input logic dw);
    init_addr = ia; init_data = id; init_we = iw;
    shuf_addr = sa; shuf_data = sd; shuf_we = sw;
    dec_addr  = da; dec_data  = dd; dec_we  = dw;
  endtask

  task automatic checkState(input string tag, input int d, input logic eb, input logic ed,
                            input logic ee, input logic [1:0] ep, input logic [2:0] es,
                            input logic ew, input logic [7:0] ea);
    if (d == 0) begin
      checkOutput({tag, "_busy"}, int'(busy_a), int'(eb));
      checkOutput({tag, "_done"}, int'(done_a), int'(ed));
      checkOutput({tag, "_error"}, int'(error_a), int'(ee));
      checkOutput({tag, "_phase"}, int'(phase_a), int'(ep));
      checkOutput({tag, "_starts"}, int'({istart_a, sstart_a, dstart_a}), int'(es));
      checkOutput({tag, "_wren"}, int'(wren_a), int'(ew));
      checkOutput({tag, "_addr"}, int'(addr_a), int'(ea));
    end else begin
      checkOutput({tag, "_busy"}, int'(busy_b), int'(eb));
      checkOutput({tag, "_done"}, int'(done_b), int'(ed));
      checkOutput({tag, "_error"}, int'(error_b), int'(ee));
      checkOutput({tag, "_phase"}, int'(phase_b), int'(ep));
      checkOutput({tag, "_starts"}, int'({istart_b, sstart_b, dstart_b}), int'(es));
      checkOutput({tag, "_wren"}, int'(wren_b), int'(ew));
      checkOutput({tag, "_addr"}, int'(addr_b), int'(ea));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int k;

  initial begin
    reset_a = 1'b1; start_a = 1'b0; ifin_a = 1'b0; sfin_a = 1'b0; dfin_a = 1'b0;
    reset_b = 1'b1; start_b = 1'b0; ifin_b = 1'b0; sfin_b = 1'b0; dfin_b = 1'b0;
    applyStimulus(8'h11, 8'hA1, 1'b1, 8'h22, 8'hB2, 1'b1, 8'h33, 8'hC3, 1'b1);
    tick(3);
    #1;
    checkState("reset_a", 0, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);
    checkState("reset_b", 1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);
    reset_a = 1'b0;
    reset_b = 1'b0;
    mon_en  = 1'b1;

    // Nominal run: 256 / 1536 / 768 engine cycles, done 2564 cycles after start
    tick(2);
    k = cyc;
    start_a = 1'b1;
    pushExp(0, K_PHASE, 1, k + 1);    pushExp(0, K_ISTART, 1, k + 1);
    pushExp(0, K_PHASE, 2, k + 258);  pushExp(0, K_SSTART, 1, k + 258);
    pushExp(0, K_PHASE, 3, k + 1795); pushExp(0, K_DSTART, 1, k + 1795);
    pushExp(0, K_PHASE, 0, k + 2564); pushExp(0, K_DONE, 1, k + 2564);
    tick(1);
    start_a = 1'b0;
    #1 checkState("init_go", 0, 1'b1, 1'b0, 1'b0, 2'd1, 3'b100, 1'b1, 8'h11);
    tick(256);
    ifin_a = 1'b1;
    tick(1);
    ifin_a = 1'b0;
    tick(10);
    applyStimulus(8'h55, 8'hEE, 1'b1, 8'hA3, 8'h3C, 1'b0, 8'h33, 8'hC3, 1'b1);
    #1;
    checkOutput("mux_shuf_wren_off", int'(wren_a), 0);
    checkOutput("mux_shuf_addr", int'(addr_a), 8'hA3);
    checkOutput("mux_shuf_data", int'(din_a), 8'h3C);
    applyStimulus(8'h55, 8'hEE, 1'b1, 8'hA3, 8'h3C, 1'b1, 8'h33, 8'hC3, 1'b1);
    #1 checkOutput("mux_shuf_wren_on", int'(wren_a), 1);
    tick(1526);
    sfin_a = 1'b1;
    tick(1);
    sfin_a = 1'b0;
    tick(5);
    applyStimulus(8'h55, 8'hEE, 1'b1, 8'hA3, 8'h3C, 1'b1, 8'h77, 8'h5A, 1'b1);
    #1;
    checkOutput("mux_dec_addr", int'(addr_a), 8'h77);
    checkOutput("mux_dec_data", int'(din_a), 8'h5A);
    tick(763);
    dfin_a = 1'b1;
    tick(1);
    dfin_a = 1'b0;
    #1 checkState("nominal_done", 0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);

    // Stale shuf_finished held through INIT_RUN must not advance the phase
    tick(2);
    k = cyc;
    start_a = 1'b1;
    pushExp(0, K_PHASE, 1, k + 1);  pushExp(0, K_ISTART, 1, k + 1);
    pushExp(0, K_PHASE, 2, k + 22); pushExp(0, K_SSTART, 1, k + 22);
    pushExp(0, K_PHASE, 3, k + 24); pushExp(0, K_DSTART, 1, k + 24);
    pushExp(0, K_PHASE, 0, k + 31); pushExp(0, K_DONE, 1, k + 31);
    tick(1);
    start_a = 1'b0;
    sfin_a  = 1'b1;
    tick(10);
    #1 checkOutput("stale_phase", int'(phase_a), 1);
    tick(10);
    ifin_a = 1'b1;
    tick(1);
    ifin_a = 1'b0;
    tick(2);
    sfin_a = 1'b0;
    tick(6);
    dfin_a = 1'b1;
    tick(1);
    dfin_a = 1'b0;
    #1 checkState("stale_done", 0, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);

    // Timeout in shuffle (16-cycle watchdog), restart, then finished on the terminal cycle
    tick(2);
    k = cyc;
    start_b = 1'b1;
    pushExp(1, K_PHASE, 1, k + 1);  pushExp(1, K_ISTART, 1, k + 1);
    pushExp(1, K_PHASE, 2, k + 6);  pushExp(1, K_SSTART, 1, k + 6);
    pushExp(1, K_PHASE, 0, k + 23); pushExp(1, K_ERR, 1, k + 23);
    pushExp(1, K_PHASE, 1, k + 26); pushExp(1, K_ISTART, 1, k + 26);
    pushExp(1, K_PHASE, 2, k + 29); pushExp(1, K_SSTART, 1, k + 29);
    pushExp(1, K_PHASE, 3, k + 31); pushExp(1, K_DSTART, 1, k + 31);
    pushExp(1, K_PHASE, 0, k + 48); pushExp(1, K_DONE, 1, k + 48);
    tick(1);
    start_b = 1'b0;
    tick(4);
    ifin_b = 1'b1;
    tick(1);
    ifin_b = 1'b0;
    tick(16);
    #1 checkOutput("pre_timeout_phase", int'(phase_b), 2);
    tick(1);
    #1 checkState("timeout", 1, 1'b0, 1'b0, 1'b1, 2'd0, 3'b000, 1'b0, 8'h00);
    tick(2);
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    #1 checkState("restart", 1, 1'b1, 1'b0, 1'b0, 2'd1, 3'b100, 1'b1, 8'h55);
    tick(2);
    ifin_b = 1'b1;
    tick(1);
    ifin_b = 1'b0;
    sfin_b = 1'b1;
    tick(2);
    sfin_b = 1'b0;
    tick(16);
    dfin_b = 1'b1;
    tick(1);
    dfin_b = 1'b0;
    #1 checkState("tie", 1, 1'b0, 1'b1, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);

    // Reset during SHUF_RUN with start held high, then start accepted from IDLE
    tick(2);
    k = cyc;
    start_b = 1'b1;
    pushExp(1, K_PHASE, 1, k + 1); pushExp(1, K_ISTART, 1, k + 1);
    pushExp(1, K_PHASE, 2, k + 3); pushExp(1, K_SSTART, 1, k + 3);
    pushExp(1, K_PHASE, 0, k + 8);
    pushExp(1, K_PHASE, 1, k + 9); pushExp(1, K_ISTART, 1, k + 9);
    tick(2);
    ifin_b = 1'b1;
    tick(1);
    ifin_b = 1'b0;
    tick(4);
    reset_b = 1'b1;
    tick(1);
    #1 checkState("mid_reset", 1, 1'b0, 1'b0, 1'b0, 2'd0, 3'b000, 1'b0, 8'h00);
    reset_b = 1'b0;
    tick(1);
    #1 checkState("after_reset", 1, 1'b1, 1'b0, 1'b0, 2'd1, 3'b100, 1'b1, 8'h55);
    start_b = 1'b0;

    tick(3);
    checkOutput("queue_a_left", q_a.size(), 0);
    checkOutput("queue_b_left", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
